sign_extend_pipe: RTL and testbench
===================================

# sign_extend_pipe

Pipelined, handshaked immediate-extension unit: widens an N-bit field to M bits in one of four modes (zero, sign, sign-and-shift, upper-place) and registers the result behind a valid/ready interface. It generalises the combinational `sign_extend` into a stall-tolerant pipeline stage. It sits between instruction decode and the ALU operand mux, so decode can stall without losing immediates.

## Interface

- `N`, default 8: input field width; N ≥ 2.
- `M`, default 16: output width; M > N.
- `SHIFT`, default 1: left-shift amount for mode 2; N + SHIFT ≤ M (elaboration-time assertion).

- `clk`  in  1  rising-edge clock; sole clock.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  input item present.
- `in_ready`  out  1  stage can accept an item.
- `in_data`  in  N  raw field.
- `in_mode`  in  2  extension mode, sampled with `in_data`.
- `out_valid`  out  1  `out_data` holds a result.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  M  extended result.

## Operation

- Transfer on the input side when `in_valid && in_ready`; on the output side when `out_valid && out_ready`.
- Mode encoding (applied to the accepted `in_data`, written as `a`):
  - 00 zero: `{(M-N)'0, a}`.
  - 01 sign: `{(M-N){a[N-1]}, a}`.
  - 10 sign-shift: sign-extend to M, then shift left by SHIFT and zero-fill; no bits are lost, per the width rule.
  - 11 upper: `{a, (M-N)'0}`.
- The transform is combinational on the input side. Only the result is stored, never the mode.
- Storage (with `SIGN_EXTEND_SKID_EN`) is a main register plus a skid register, each with a valid bit:
  - Accepting while the main register is empty or draining this cycle: the item goes to the main register.
  - Accepting while the main register is full and stalled: the item goes to the skid register.
  - When the main register drains and the skid register is full: the skid entry moves to main in the same cycle.
- The pipeline is in order, with no drops and no duplicates.
- `out_data` is held stable while `out_valid && !out_ready`.

## Timing

- Reset values: `out_valid` 0, `out_data` 0, skid valid 0, `in_ready` 1 in the cycle after `rst`.
- Reset mid-operation discards all held items.
- `in_valid` is ignored while `rst` is high.
- Latency is 1 cycle: an item accepted at edge k is presented with `out_valid` = 1 after edge k.
- Throughput is 1 item/cycle while `out_ready` = 1.
- With skid: `in_ready` is a registered signal, equal to `!skid_valid`. There is no combinational path from `out_ready` to `in_ready`.
- Simultaneous accept and drain with the skid register empty: main is reloaded with the new item and `out_valid` stays 1.
- Both registers full: `in_ready` = 0. It returns to 1 the cycle after the first drain.

## Configuration

- `SIGN_EXTEND_SKID_EN` defined: two-entry storage as above, with registered `in_ready`.
- `SIGN_EXTEND_SKID_EN` undefined: the skid register is removed, leaving a single register.
  - `in_ready = !out_valid || out_ready`, which is combinational.
  - Full throughput is still reached when `out_ready` = 1.
  - Functional results and latency are identical to the skid build.

## Test plan

- N=8, M=16, mode 01 → outputs one cycle later, in order:
  - `in_data`=8'h7F → `out_data`=16'h007F.
  - `in_data`=8'hFF → 16'hFFFF.
  - `in_data`=8'h00 → 16'h0000.
- Mode 00 with 8'hFF → 16'h00FF. Mode 11 with 8'hA5 → 16'hA500. Mode 10 (SHIFT=1):
  - 8'h80 → 16'hFF00.
  - 8'h40 → 16'h0080.
- Stream 16 random items with `out_ready` = 1 → one result per cycle, each matching the reference model, with no bubbles.
- Backpressure, skid build: hold `out_ready` = 0 and offer 8'h01 then 8'h02 in mode 01.
  - Both are accepted; `in_ready` = 0 next cycle; `out_data` holds 16'h0001.
  - Raise `out_ready` → 16'h0001 then 16'h0002 on consecutive cycles, and `in_ready` returns to 1.
- Same backpressure stimulus, non-skid build → only 8'h01 is accepted. `in_ready` = 0 while `out_valid && !out_ready`.
- Assert `rst` for 1 cycle with both registers full → next cycle `out_valid` = 0, `out_data` = 0, `in_ready` = 1, and no stale item ever appears.

Source files
------------

// File: rtl/sign_extend_pipe.sv
// Immediate-extension pipeline stage (zero/sign/sign-shift/upper); SIGN_EXTEND_SKID_EN adds a skid register.
// Latency 1 cycle, throughput 1 item/cycle while out_ready is high; results held stable while stalled.
// Backpressure: skid build has registered in_ready (!skid_valid); default build has in_ready = !out_valid || out_ready.
module sign_extend_pipe #(
  parameter int N     = 8,
  parameter int M     = 16,
  parameter int SHIFT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [1:0]   in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_data
);

  generate
    if (N < 2 || M <= N || N + SHIFT > M) begin : g_bad_params
      $error("sign_extend_pipe: need N >= 2, M > N and N + SHIFT <= M");
    end
  endgenerate

  function automatic logic [M-1:0] extend(input logic [N-1:0] a, input logic [1:0] mode);
    logic [M-1:0] sx;
    sx = {{(M-N){a[N-1]}}, a};
    case (mode)
      2'b00:   extend = {{(M-N){1'b0}}, a};
      2'b01:   extend = sx;
      2'b10:   extend = sx << SHIFT;
      default: extend = {a, {(M-N){1'b0}}};
    endcase
  endfunction

  logic [M-1:0] ext_data;
  logic         accept;
  logic         drain;
  logic         main_valid;
  logic [M-1:0] main_data;

  always_comb begin
    ext_data = extend(in_data, in_mode);
  end

  assign accept    = in_valid && in_ready;
  assign drain     = main_valid && out_ready;
  assign out_valid = main_valid;
  assign out_data  = main_data;

`ifdef SIGN_EXTEND_SKID_EN
  logic         skid_valid;
  logic [M-1:0] skid_data;

  // in_ready comes straight from a flop, so out_ready never reaches it combinationally.
  assign in_ready = !skid_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (skid_valid) begin
      // in_ready is low here, so the only possible event is a drain refilling main from skid.
      if (drain) begin
        main_data  <= skid_data;
        skid_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!main_valid || drain) begin
        main_data  <= ext_data;
        main_valid <= 1'b1;
      end else begin
        skid_data  <= ext_data;
        skid_valid <= 1'b1;
      end
    end else if (drain) begin
      main_valid <= 1'b0;
    end
  end
`else
  assign in_ready = !main_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_data  <= '0;
    end else if (accept) begin
      main_data  <= ext_data;
      main_valid <= 1'b1;
    end else if (drain) begin
      main_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_sign_extend_pipe.sv
// Bench for sign_extend_pipe: queue-based reference model plus directed literal vectors.
// Builds against either configuration; SIGN_EXTEND_SKID_EN selects the expected in_ready behaviour.
module tb_sign_extend_pipe;

  localparam int N     = 8;
  localparam int M     = 16;
  localparam int SHIFT = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic [1:0]   in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [M-1:0] out_data;

  int n_checks = 0;
  int n_pass   = 0;

  logic [M-1:0] q[$];

  sign_extend_pipe #(.N(N), .M(M), .SHIFT(SHIFT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Extension rules in plain integer arithmetic.
  function automatic logic [M-1:0] ref_ext(input logic [N-1:0] a, input logic [1:0] m);
    int u;
    int s;
    u = int'(a);
    s = (u >= (1 << (N-1))) ? u - (1 << N) : u;
    case (m)
      2'd0:    return M'(u);
      2'd1:    return M'(s);
      2'd2:    return M'(s * (1 << SHIFT));
      default: return M'(u * (1 << (M-N)));
    endcase
  endfunction

  // Scoreboard: everything accepted and not yet drained is held, oldest at the output.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && in_ready) q.push_back(ref_ext(in_data, in_mode));
    end
    #1;
    check("sb_out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) check("sb_out_data", 32'(out_data), 32'(q[0]));
`ifdef SIGN_EXTEND_SKID_EN
    check("sb_in_ready", 32'(in_ready), 32'(q.size() < 2));
`else
    check("sb_in_ready", 32'(in_ready), 32'(q.size() == 0 || out_ready));
`endif
  end

  logic [N-1:0] tbl_d [7] = '{8'h7F, 8'hFF, 8'h00, 8'hFF, 8'hA5, 8'h80, 8'h40};
  logic [1:0]   tbl_m [7] = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd3, 2'd2, 2'd2};
  logic [M-1:0] tbl_e [7] = '{16'h007F, 16'hFFFF, 16'h0000, 16'h00FF, 16'hA500, 16'hFF00, 16'h0080};

  initial begin
    int run;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk) rst = 1'b0;

    // Directed vectors, back to back, each visible one edge after acceptance.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = tbl_d[i]; in_mode = tbl_m[i];
      @(posedge clk); #2;
      check("dir_valid", 32'(out_valid), 32'd1);
      check("dir_data",  32'(out_data),  32'(tbl_e[i]));
    end
    @(negedge clk) in_valid = 1'b0;

    // Random stream at full rate.
    run = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = N'($urandom_range(0, 255));
      in_mode  = 2'($urandom_range(0, 3));
      @(posedge clk); #2;
      if (out_valid) run++;
    end
    @(negedge clk) in_valid = 1'b0;
    check("stream_no_bubbles", 32'(run), 32'd16);

    // Backpressure.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h01; in_mode = 2'd1;
    @(posedge clk); #2;
    check("bp_first_valid", 32'(out_valid), 32'd1);
    check("bp_first_data",  32'(out_data),  32'h0001);
    @(negedge clk) in_data = 8'h02;
    @(posedge clk); #2;
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    check("bp_hold_data",    32'(out_data), 32'h0001);
`ifdef SIGN_EXTEND_SKID_EN
    @(negedge clk) in_valid = 1'b0;
`else
    @(negedge clk);
`endif
    @(posedge clk); #2;
    check("bp_stall_data",  32'(out_data), 32'h0001);
    check("bp_stall_ready", 32'(in_ready), 32'd0);
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #2;
    check("bp_second_valid", 32'(out_valid), 32'd1);
    check("bp_second_data",  32'(out_data),  32'h0002);
    check("bp_ready_back",   32'(in_ready),  32'd1);
    @(negedge clk) in_valid = 1'b0;
    @(posedge clk); #2;
    check("bp_empty", 32'(out_valid), 32'd0);

    // Reset while full; the item offered during reset must be ignored.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h11; in_mode = 2'd0;
    @(negedge clk) in_data = 8'h22;
    @(negedge clk) begin rst = 1'b1; in_data = 8'h33; end
    @(posedge clk); #2;
    check("rstmid_out_valid", 32'(out_valid), 32'd0);
    check("rstmid_out_data",  32'(out_data),  32'd0);
    check("rstmid_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk) begin rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; end
    run = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      if (out_valid) run++;
    end
    check("rstmid_no_stale", 32'(run), 32'd0);
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hC3; in_mode = 2'd1;
    @(posedge clk); #2;
    check("post_rst_data", 32'(out_data), 32'hFFC3);
    @(negedge clk) in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
